// File: rtl/packet_gen_param.sv
// packet_gen_param -- parameterised packet generator feeding a router.
//
// Purpose:
//   While start_packet_gen is high and stop_packet is low, emits packets made of
//   dstid, srcid, actual_size (zero-extended) and actual_size payload words
//   (srcid + i). The router channel is dstid[1:0]. A packet whose channel is
//   not below NUM_DEST is dropped with a one-cycle err_dest pulse. Per-channel
//   backpressure (dest_busy) freezes a packet in progress. Every packet is
//   followed by a one-cycle GAP state.
//
// Optional feature:
//   Define PKT_PARITY_EN to append a parity word (the XOR of all earlier words
//   of the packet). packet_ending then falls on that word.
//
// Ports:
//   clk                input   sole clock, rising edge
//   rst                input   synchronous reset, active low
//   start_packet_gen   input   level, generate packets back-to-back
//   stop_packet        input   level, hold off new packets
//   srcid, dstid       input   [DATA_W-1:0] source ID / destination header
//   actual_size        input   [LEN_W-1:0] payload word count
//   dest_busy          input   [NUM_DEST-1:0] per-channel backpressure
//   packet_gen_output  output  [DATA_W-1:0] registered packet word
//   packet_gen_valid   output  word valid
//   packet_starting    output  high with the header word
//   packet_ending      output  high with the last word
//   err_dest           output  pulse when a packet is dropped (bad channel)
//   pkt_count          output  [15:0] completed packets, wraps

module packet_gen_param #(
    parameter int DATA_W   = 8,
    parameter int LEN_W    = 3,
    parameter int NUM_DEST = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_packet_gen,
    input  logic                stop_packet,
    input  logic [DATA_W-1:0]   srcid,
    input  logic [DATA_W-1:0]   dstid,
    input  logic [LEN_W-1:0]    actual_size,
    input  logic [NUM_DEST-1:0] dest_busy,
    output logic [DATA_W-1:0]   packet_gen_output,
    output logic                packet_gen_valid,
    output logic                packet_starting,
    output logic                packet_ending,
    output logic                err_dest,
    output logic [15:0]         pkt_count
);

    // The state names the word currently on the output (HDR..PAR), so the
    // decision made in a state is about the word that follows it.
    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SRC,
        LEN,
        DATA,
`ifdef PKT_PARITY_EN
        PAR,
`endif
        GAP
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   srcid_q, srcid_d;
    logic [DATA_W-1:0]   dstid_q, dstid_d;
    logic [LEN_W-1:0]    size_q, size_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                valid_q, valid_d;
    logic                starting_q, starting_d;
    logic                ending_q, ending_d;
    logic                err_q, err_d;
    logic [15:0]         count_q, count_d;
`ifdef PKT_PARITY_EN
    logic [DATA_W-1:0]   parity_q, parity_d;
`endif

    logic [3:0]          busy_ext;
    logic                in_ch_ok;
    logic                emit;
    logic [DATA_W-1:0]   word;
    logic [LEN_W-1:0]    idx_inc;

    // Busy is widened to four channels so an out-of-range channel index never
    // selects outside the vector; unused channels read as not busy.
    always_comb begin
        busy_ext                 = '0;
        busy_ext[NUM_DEST-1:0]   = dest_busy;
    end

    assign in_ch_ok = ({30'b0, dstid[1:0]} < 32'(NUM_DEST));
    assign idx_inc  = idx_q + LEN_W'(1);

    // Next-state and next-output logic. Every output is registered, so the
    // word chosen here appears one cycle later. A stall holds the state and
    // index and produces a bubble; the following word comes out on resume.
    always_comb begin
        state_d    = state_q;
        srcid_d    = srcid_q;
        dstid_d    = dstid_q;
        size_d     = size_q;
        idx_d      = idx_q;
        out_d      = '0;
        valid_d    = 1'b0;
        starting_d = 1'b0;
        ending_d   = 1'b0;
        err_d      = 1'b0;
        count_d    = ending_q ? count_q + 16'd1 : count_q;
        emit       = 1'b0;
        word       = '0;
`ifdef PKT_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_packet_gen && !stop_packet) begin
                    if (!in_ch_ok) begin
                        err_d   = 1'b1;
                        state_d = GAP;
                    end else if (!busy_ext[dstid[1:0]]) begin
                        srcid_d    = srcid;
                        dstid_d    = dstid;
                        size_d     = actual_size;
                        idx_d      = '0;
                        state_d    = HDR;
                        emit       = 1'b1;
                        word       = dstid;
                        starting_d = 1'b1;
`ifdef PKT_PARITY_EN
                        parity_d   = '0;
`endif
                    end
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                if (!busy_ext[dstid_q[1:0]]) begin
                    case (state_q)
                        HDR: begin
                            state_d = SRC;
                            emit    = 1'b1;
                            word    = srcid_q;
                        end
                        SRC: begin
                            state_d  = LEN;
                            emit     = 1'b1;
                            word     = DATA_W'(size_q);
`ifndef PKT_PARITY_EN
                            ending_d = (size_q == '0);
`endif
                        end
                        LEN, DATA: begin
                            if (idx_q < size_q) begin
                                state_d  = DATA;
                                emit     = 1'b1;
                                word     = srcid_q + DATA_W'(idx_q);
                                idx_d    = idx_inc;
`ifndef PKT_PARITY_EN
                                ending_d = (idx_inc == size_q);
`endif
                            end else begin
`ifdef PKT_PARITY_EN
                                state_d  = PAR;
                                emit     = 1'b1;
                                word     = parity_q;
                                ending_d = 1'b1;
`else
                                state_d  = GAP;
`endif
                            end
                        end
`ifdef PKT_PARITY_EN
                        PAR: begin
                            state_d = GAP;
                        end
`endif
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
        endcase

        if (emit) begin
            out_d    = word;
            valid_d  = 1'b1;
`ifdef PKT_PARITY_EN
            parity_d = parity_d ^ word;
`endif
        end
    end

    // State and output registers with synchronous active-low reset; reset
    // drops any packet in flight, including a pending count increment.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            srcid_q    <= '0;
            dstid_q    <= '0;
            size_q     <= '0;
            idx_q      <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            starting_q <= 1'b0;
            ending_q   <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
`ifdef PKT_PARITY_EN
            parity_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            srcid_q    <= srcid_d;
            dstid_q    <= dstid_d;
            size_q     <= size_d;
            idx_q      <= idx_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            starting_q <= starting_d;
            ending_q   <= ending_d;
            err_q      <= err_d;
            count_q    <= count_d;
`ifdef PKT_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign packet_gen_output = out_q;
    assign packet_gen_valid  = valid_q;
    assign packet_starting   = starting_q;
    assign packet_ending     = ending_q;
    assign err_dest          = err_q;
    assign pkt_count         = count_q;

endmodule

// File: tb/tb_packet_gen_param.sv
// tb_packet_gen_param -- self-checking bench for packet_gen_param.
//
// A transaction-level model builds each expected packet as a queue of words
// when a start is accepted and releases one word per unstalled cycle. Directed
// scenarios are followed by a randomized phase. Honours PKT_PARITY_EN.

module tb_packet_gen_param;

    localparam int DATA_W   = 8;
    localparam int LEN_W    = 3;
    localparam int NUM_DEST = 3;

    localparam int M_IDLE = 0;
    localparam int M_PKT  = 1;
    localparam int M_GAP  = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start_packet_gen = 1'b0;
    logic                stop_packet = 1'b0;
    logic [DATA_W-1:0]   srcid = '0;
    logic [DATA_W-1:0]   dstid = '0;
    logic [LEN_W-1:0]    actual_size = '0;
    logic [NUM_DEST-1:0] dest_busy = '0;

    logic [DATA_W-1:0]   packet_gen_output;
    logic                packet_gen_valid;
    logic                packet_starting;
    logic                packet_ending;
    logic                err_dest;
    logic [15:0]         pkt_count;

    packet_gen_param #(
        .DATA_W   (DATA_W),
        .LEN_W    (LEN_W),
        .NUM_DEST (NUM_DEST)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_packet_gen  (start_packet_gen),
        .stop_packet       (stop_packet),
        .srcid             (srcid),
        .dstid             (dstid),
        .actual_size       (actual_size),
        .dest_busy         (dest_busy),
        .packet_gen_output (packet_gen_output),
        .packet_gen_valid  (packet_gen_valid),
        .packet_starting   (packet_starting),
        .packet_ending     (packet_ending),
        .err_dest          (err_dest),
        .pkt_count         (pkt_count)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    int                mode   = M_IDLE;
    int                pkt_ch = 0;
    logic [DATA_W-1:0] wq[$];
    logic [DATA_W-1:0] exp_word  = '0;
    logic              exp_valid = 1'b0;
    logic              exp_start = 1'b0;
    logic              exp_end   = 1'b0;
    logic              exp_err   = 1'b0;
    logic [15:0]       exp_count = '0;

    // Words observed on the DUT output, used by the directed scenarios.
    logic [DATA_W-1:0] seen[$];

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    // Expected packet contents straight from the word-order rules.
    task automatic buildPacket();
        logic [DATA_W-1:0] p;
        wq.delete();
        wq.push_back(dstid);
        wq.push_back(srcid);
        wq.push_back(DATA_W'(actual_size));
        for (int i = 0; i < int'(actual_size); i++)
            wq.push_back(srcid + DATA_W'(i));
`ifdef PKT_PARITY_EN
        p = '0;
        foreach (wq[i]) p = p ^ wq[i];
        wq.push_back(p);
`else
        p = '0;
`endif
    endtask

    task automatic popWord();
        exp_word  = wq.pop_front();
        exp_valid = 1'b1;
        exp_end   = (wq.size() == 0);
    endtask

    // Advance the model by one clock using the inputs present this cycle;
    // the exp_* values are what the DUT must show after the coming edge.
    task automatic modelStep();
        int ch;
        if (!rst) begin
            mode      = M_IDLE;
            wq.delete();
            exp_word  = '0;
            exp_valid = 1'b0;
            exp_start = 1'b0;
            exp_end   = 1'b0;
            exp_err   = 1'b0;
            exp_count = '0;
            return;
        end
        if (exp_end) exp_count = exp_count + 16'd1;
        exp_word  = '0;
        exp_valid = 1'b0;
        exp_start = 1'b0;
        exp_end   = 1'b0;
        exp_err   = 1'b0;
        case (mode)
            M_IDLE: begin
                if (start_packet_gen && !stop_packet) begin
                    ch = int'(dstid[1:0]);
                    if (ch >= NUM_DEST) begin
                        exp_err = 1'b1;
                        mode    = M_GAP;
                    end else if (!dest_busy[ch]) begin
                        buildPacket();
                        pkt_ch    = ch;
                        popWord();
                        exp_start = 1'b1;
                        mode      = M_PKT;
                    end
                end
            end
            M_GAP: mode = M_IDLE;
            default: begin
                if (!dest_busy[pkt_ch]) begin
                    if (wq.size() == 0) mode = M_GAP;
                    else popWord();
                end
            end
        endcase
    endtask

    // One clock: step the model, let the edge pass, compare all outputs.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput("valid",    32'(packet_gen_valid),  32'(exp_valid));
        checkOutput("word",     32'(packet_gen_output), 32'(exp_word));
        checkOutput("starting", 32'(packet_starting),   32'(exp_start));
        checkOutput("ending",   32'(packet_ending),     32'(exp_end));
        checkOutput("err_dest", 32'(err_dest),          32'(exp_err));
        checkOutput("pkt_count",32'(pkt_count),         32'(exp_count));
        if (packet_gen_valid) seen.push_back(packet_gen_output);
    endtask

    task automatic runUntilEnd(input int budget);
        int n = 0;
        do begin
            applyStimulus();
            n++;
        end while (!exp_end && n < budget);
        if (!exp_end) checkOutput("end_timeout", 32'(packet_ending), 32'd1);
    endtask

    task automatic runUntilIdle(input int budget);
        int n = 0;
        while (mode != M_IDLE && n < budget) begin
            applyStimulus();
            n++;
        end
        if (mode != M_IDLE) checkOutput("idle_timeout", 32'(packet_gen_valid), 32'd0);
    endtask

    // Watchdog so the run always ends even if the clock loop stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [DATA_W-1:0] s1_exp[$];

        // Reset held for two cycles.
        rst = 1'b0;
        applyStimulus();
        applyStimulus();

        // Scenario 1: basic packet srcid=05, dstid=F8, size=4.
        rst = 1'b1;
        start_packet_gen = 1'b1;
        srcid = 8'h05; dstid = 8'hF8; actual_size = 3'd4;
        seen.delete();
        runUntilEnd(40);
        s1_exp = '{8'hF8, 8'h05, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef PKT_PARITY_EN
        s1_exp.push_back(8'hF5);
`endif
        checkOutput("s1_len", 32'(seen.size()), 32'(s1_exp.size()));
        for (int i = 0; i < s1_exp.size(); i++)
            if (i < seen.size()) checkOutput($sformatf("s1_word%0d", i), 32'(seen[i]), 32'(s1_exp[i]));

        // Scenario 2: stop held three cycles after the ending word.
        stop_packet = 1'b1;
        srcid = 8'h06; dstid = 8'h08; actual_size = 3'd5;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("s2_stop_valid", 32'(packet_gen_valid), 32'd0);
            if (i == 0) checkOutput("s1_count", 32'(pkt_count), 32'd1);
        end
        stop_packet = 1'b0;
        applyStimulus();
        checkOutput("s2_start", 32'(packet_starting), 32'd1);
        checkOutput("s2_hdr", 32'(packet_gen_output), 32'h08);
        start_packet_gen = 1'b0;
        runUntilEnd(40);
        runUntilIdle(10);

        // Scenario 3: invalid channel (dstid[1:0]=3 with three channels).
        start_packet_gen = 1'b1;
        srcid = 8'h11; dstid = 8'h0F; actual_size = 3'd2;
        applyStimulus();
        checkOutput("s3_err", 32'(err_dest), 32'd1);
        start_packet_gen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("s3_err_off", 32'(err_dest), 32'd0);
            checkOutput("s3_valid", 32'(packet_gen_valid), 32'd0);
        end
        checkOutput("s3_count", 32'(pkt_count), 32'd2);

        // Scenario 4: channel 1 busy for two cycles right after the SRC word.
        start_packet_gen = 1'b1;
        srcid = 8'h06; dstid = 8'h45; actual_size = 3'd7;
        applyStimulus();
        start_packet_gen = 1'b0;
        applyStimulus();
        checkOutput("s4_src_word", 32'(packet_gen_output), 32'h06);
        dest_busy = 3'b010;
        applyStimulus();
        checkOutput("s4_stall1", 32'(packet_gen_valid), 32'd0);
        applyStimulus();
        checkOutput("s4_stall2", 32'(packet_gen_valid), 32'd0);
        dest_busy = 3'b000;
        applyStimulus();
        checkOutput("s4_resume_word", 32'(packet_gen_output), 32'h07);
        runUntilEnd(40);
        runUntilIdle(10);

        // Scenario 5: empty payload.
        start_packet_gen = 1'b1;
        srcid = 8'h33; dstid = 8'h02; actual_size = 3'd0;
        seen.delete();
        applyStimulus();
        start_packet_gen = 1'b0;
        runUntilEnd(20);
`ifdef PKT_PARITY_EN
        checkOutput("s5_words", 32'(seen.size()), 32'd4);
`else
        checkOutput("s5_words", 32'(seen.size()), 32'd3);
`endif
        runUntilIdle(10);

        // Scenario 6: reset during DATA, then counter wrap from FFFF.
        start_packet_gen = 1'b1;
        srcid = 8'h40; dstid = 8'h01; actual_size = 3'd7;
        applyStimulus();
        start_packet_gen = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();
        rst = 1'b0;
        applyStimulus();
        checkOutput("s6_rst_valid", 32'(packet_gen_valid), 32'd0);
        checkOutput("s6_rst_ending", 32'(packet_ending), 32'd0);
        checkOutput("s6_rst_count", 32'(pkt_count), 32'd0);
        rst = 1'b1;
        applyStimulus();
        applyStimulus();
        force dut.count_q = 16'hFFFF;
        exp_count = 16'hFFFF;
        applyStimulus();
        release dut.count_q;
        start_packet_gen = 1'b1;
        srcid = 8'h20; dstid = 8'h00; actual_size = 3'd1;
        applyStimulus();
        start_packet_gen = 1'b0;
        runUntilEnd(20);
        applyStimulus();
        checkOutput("s6_wrap", 32'(pkt_count), 32'd0);

        // Randomized traffic: fields change every cycle, rare resets,
        // occasional stops, invalid channels and backpressure.
        for (int c = 0; c < 600; c++) begin
            rst              = ($urandom_range(0, 99) != 0);
            start_packet_gen = ($urandom_range(0, 9) < 7);
            stop_packet      = ($urandom_range(0, 9) == 0);
            srcid            = DATA_W'($urandom);
            dstid            = DATA_W'($urandom);
            actual_size      = LEN_W'($urandom);
            for (int b = 0; b < NUM_DEST; b++)
                dest_busy[b] = ($urandom_range(0, 4) == 0);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
